// File: rtl/pwl_reg_sequencer.sv
// Scripted register-port initiator for the PWL synth peripheral: queued write/read
// commands are replayed as single-cycle writes or held read strobes, each followed by a programmable idle delay.
module pwl_reg_sequencer #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned WAIT_BITS    = 16,
   parameter int unsigned READ_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_read,
   input  logic [1:0]           cmd_size,
   input  logic [5:0]           cmd_addr,
   input  logic [31:0]          cmd_data,
   input  logic [WAIT_BITS-1:0] cmd_wait,
   output logic [5:0]           address,
   output logic [31:0]          data_in,
   output logic [1:0]           data_write_n,
   output logic [1:0]           data_read_n,
   input  logic [31:0]          data_out,
   input  logic                 data_ready,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 busy
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMO_W = $clog2(READ_TIMEOUT + 1);

   typedef struct packed {
      logic                 rd;
      logic [1:0]           size;
      logic [5:0]           addr;
      logic [31:0]          data;
      logic [WAIT_BITS-1:0] wt;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RD,
      S_WAIT
   } state_t;

   cmd_t                 r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wptr;
   logic [PTR_W-1:0]     r_rptr;
   logic [CNT_W-1:0]     r_count;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_rd;
   logic [WAIT_BITS-1:0] r_wait;
   logic [WAIT_BITS-1:0] r_wcnt;
   logic [TMO_W-1:0]     r_tmo;
   logic [5:0]           r_address;
   logic [31:0]          r_data_in;
   logic [1:0]           r_write_n;
   logic [1:0]           r_read_n;
   logic                 r_rsp_valid;
   logic [31:0]          r_rsp_data;
   logic                 r_rsp_err;

   cmd_t                 w_cmd_in;
   cmd_t                 w_head;
   logic [1:0]           w_head_size;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_has_wait;
   logic                 w_rd_tmo;
   logic                 w_rd_done;
   logic                 w_strobe_end;
   logic                 w_rsp_fire;
   logic                 w_tmo_inc;
   logic                 w_wait_dec;

   // ---------------- command FIFO ----------------
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && !w_full;
   assign w_cmd_in  = '{rd: cmd_read, size: cmd_size, addr: cmd_addr, data: cmd_data, wt: cmd_wait};
   assign w_head    = r_mem[r_rptr];
   // size code 11 is issued as a word access
   assign w_head_size = (w_head.size == 2'b11) ? 2'b10 : w_head.size;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_cmd_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- sequencer FSM ----------------
   assign w_has_wait = (r_wait != '0);
   assign w_rd_tmo   = (r_tmo == TMO_W'(READ_TIMEOUT - 1));
   assign w_rd_done  = data_ready || w_rd_tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!r_rd || w_rd_done) begin
               w_state_nxt = w_has_wait ? S_WAIT : S_IDLE;
            end else begin
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            if (w_rd_done) begin
               w_state_nxt = w_has_wait ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WAIT_BITS'(1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes are registered, so they are set on the IDLE->ISSUE transition
   // and cleared on the transition out of ISSUE/RD.
   always_comb begin
      w_pop        = 1'b0;
      w_strobe_end = 1'b0;
      w_rsp_fire   = 1'b0;
      w_tmo_inc    = 1'b0;
      w_wait_dec   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pop = !w_empty;
         end
         S_ISSUE, S_RD: begin
            if (!r_rd) begin
               w_strobe_end = 1'b1;
            end else if (w_rd_done) begin
               w_strobe_end = 1'b1;
               w_rsp_fire   = 1'b1;
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         S_WAIT: begin
            w_wait_dec = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd        <= 1'b0;
         r_wait      <= '0;
         r_wcnt      <= '0;
         r_tmo       <= '0;
         r_address   <= '0;
         r_data_in   <= '0;
         r_write_n   <= '1;
         r_read_n    <= '1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_rsp_fire;
         if (w_pop) begin
            r_rd      <= w_head.rd;
            r_wait    <= w_head.wt;
            r_tmo     <= '0;
            r_address <= w_head.addr;
            r_data_in <= w_head.data;
            if (w_head.rd) begin
               r_read_n <= w_head_size;
            end else begin
               r_write_n <= w_head_size;
            end
         end
         if (w_strobe_end) begin
            r_write_n <= '1;
            r_read_n  <= '1;
            r_wcnt    <= r_wait;
         end
         if (w_tmo_inc) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
         if (w_wait_dec) begin
            r_wcnt <= r_wcnt - WAIT_BITS'(1);
         end
         if (w_rsp_fire) begin
            r_rsp_data <= data_ready ? data_out : '0;
            r_rsp_err  <= !data_ready;
         end
      end
   end

   assign address      = r_address;
   assign data_in      = r_data_in;
   assign data_write_n = r_write_n;
   assign data_read_n  = r_read_n;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_err      = r_rsp_err;
   assign busy         = !w_empty || (r_state != S_IDLE);

endmodule

// File: doc/pwl_reg_sequencer.md
Name: pwl_reg_sequencer

Overview:
- Host-side initiator for the synth peripheral's register port. It drives address, data_in, data_write_n and data_read_n into tqvp_toivoh_pwl_synth and consumes data_out and data_ready.
- Plays a queued script of register writes and reads with programmable inter-command delays. This allows note/sweep/slope updates to land on exact cycles in simulation and on FPGA bring-up, without a CPU.
- Sits between a command source (bench, UART bridge) and the peripheral.

Parameters:
- DEPTH, 8: command FIFO entries; power of two, minimum 2.
- WAIT_BITS, 16: width of the per-command post-delay.
- READ_TIMEOUT, 64: cycles to hold a read strobe without data_ready before aborting.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as 10.
- cmd_addr  in  6  register address.
- cmd_data  in  32  write data; ignored for reads.
- cmd_wait  in  WAIT_BITS  idle cycles inserted after the command completes.
- address  out  6  to peripheral.
- data_in  out  32  to peripheral.
- data_write_n  out  2  11 = idle, otherwise size code.
- data_read_n  out  2  11 = idle, otherwise size code.
- data_out  in  32  peripheral read data.
- data_ready  in  1  peripheral read data valid.
- rsp_valid  out  1  one-cycle pulse, read completed or aborted.
- rsp_data  out  32  captured read data; 0 on timeout.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset values (async, immediate):
  - data_write_n = data_read_n = 11.
  - address = 0, data_in = 0.
  - rsp_valid = rsp_err = 0, rsp_data = 0.
  - FIFO emptied, FSM in IDLE, busy = 0, cmd_ready = 1.
- All peripheral-side outputs are registered.
- FIFO:
  - A push occurs when cmd_valid && cmd_ready.
  - No fall-through: cmd_ready depends only on the registered count.
  - A push and a pop in the same cycle is allowed when not full; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- IDLE state:
  - If the FIFO is non-empty, pop and load address, data_in, size, read flag and wait into registers; go to ISSUE.
  - Otherwise stay in IDLE with strobes at 11.
- ISSUE state, write command:
  - data_write_n = size code for exactly one cycle, with address/data_in stable.
  - Next state is WAIT if wait > 0, else IDLE.
- ISSUE state, read command:
  - data_read_n = size code; go to RD.
- RD state:
  - Hold data_read_n and address.
  - On data_ready = 1 (sampled in ISSUE or RD): capture data_out into rsp_data, pulse rsp_valid with rsp_err = 0, and deassert data_read_n next cycle.
  - Timeout: if the strobe has been held READ_TIMEOUT cycles with no data_ready, deassert, pulse rsp_valid with rsp_err = 1 and rsp_data = 0.
  - Then go to WAIT if wait > 0, else IDLE.
- WAIT state:
  - Down-counter loaded with wait; decrements each cycle.
  - Leaves to IDLE in the cycle after it reads 1, so exactly W cycles are spent in WAIT.
- Timing:
  - Push at cycle N into an empty, idle block gives the first strobe at N+2.
  - A write strobe at S with wait W gives the earliest next strobe at S+2+W.
- data_ready while no read strobe is active is ignored.
- Outside ISSUE/RD, data_in and address hold their last values; only the strobes are idle.
- Reset mid-operation: strobes return to 11 asynchronously; the queued commands are discarded.

Test Plan:
- Reset: drive rst_n = 0 mid-read with data_read_n = 10 -> data_read_n = 11 immediately, busy = 0, cmd_ready = 1, rsp_valid never pulses.
- Back-to-back writes: push addr 0x00/data 0x0000_1234/word/wait 0, then addr 0x04/data 0x0000_0ABC/halfword/wait 0 -> data_write_n = 10 at cycle N+2, 01 at N+4; period0 = 0x1234 in the peripheral afterwards.
- Delay: write with wait 5 followed by a write -> strobes exactly 7 cycles apart; busy stays 1 throughout.
- Read: push read addr 0x08 word; peripheral asserts data_ready 3 cycles after the strobe with data_out = 0xDEAD_BEEF -> data_read_n = 10 held 4 cycles, rsp_valid = 1 for one cycle, rsp_data = 0xDEADBEEF, rsp_err = 0.
- Timeout: read with data_ready tied 0 -> strobe held 64 cycles, then rsp_valid = 1, rsp_err = 1, rsp_data = 0; next command proceeds.
- FIFO full: push 9 commands while the FSM is stalled in a wait 100 command -> cmd_ready = 0 after 8 accepted; the 9th is held; all 8 issue in order after the wait, and the pointer wrap is verified.
